key_frame_rx: RTL and testbench

- Host-side reader for the 16-bit keypad-state stream that the keyboard scanner sends over UART as two bytes: high byte first, then low byte.
- Sits after uart_rx. It edge-detects the receive strobe, pairs bytes into frames, re-synchronises on an inter-byte timeout, and presents the latest key state with a decoded key index.

---
 rtl/key_frame_rx.sv | 210 +++++++++++++++++++++
 tb/tb_key_frame_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_frame_rx.sv
// ---------------------------------------------------------------------------
// key_frame_rx
// Host-side reader for the two-byte keypad-state stream coming out of
// uart_rx. The high byte arrives first, then the low byte. The block turns
// the receive strobe into single byte events and pairs those bytes into
// 16-bit frames. It drops a half frame if the low byte does not arrive in
// time, and it presents the latest key state together with a decoded key
// index.
//
// Optional feature (compile-time macro KEY_EDGE_EN):
//   defined   - press_mask / release_mask report the bits that changed at
//               each commit (new & ~old, old & ~new).
//   undefined - both masks are tied to 0. No mask logic is built.
//
// Parameters:
//   TIMEOUT_CYCLES  max clk cycles between the high and low byte (>= 2)
//   CNT_W           inter-byte timer width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   rx_irq        byte-ready strobe from uart_rx (may be held high)
//   rx_data       received byte, valid when rx_irq first rises
//   keyout        last complete frame {hi, lo}
//   key_valid     one-cycle pulse when keyout is updated
//   key_any       OR of keyout bits
//   key_code      index of the lowest set bit of keyout (0 when keyout is 0)
//   frame_cnt     committed frame count, wraps 255 -> 0
//   timeout_err   one-cycle pulse when a half frame is discarded
//   press_mask    bits newly set by the last commit (KEY_EDGE_EN)
//   release_mask  bits newly cleared by the last commit (KEY_EDGE_EN)
//
// State table:
//   S_IDLE    | waiting for a high byte
//   S_WAIT_LO | high byte held, timing the gap to the low byte
//   S_COMMIT  | one cycle: publish {hi, lo} and the derived outputs
// ---------------------------------------------------------------------------
module key_frame_rx #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_irq,
    input  logic [7:0]  rx_data,
    output logic [15:0] keyout,
    output logic        key_valid,
    output logic        key_any,
    output logic [3:0]  key_code,
    output logic [7:0]  frame_cnt,
    output logic        timeout_err,
    output logic [15:0] press_mask,
    output logic [15:0] release_mask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_LO = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              irq_d_q;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       keyout_q, keyout_d;
    logic              key_valid_q, key_valid_d;
    logic              key_any_q, key_any_d;
    logic [3:0]        key_code_q, key_code_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              byte_ev;
    logic [15:0]       new_word;

    // Lowest set bit wins. The loop runs from the top bit down, so the last
    // assignment is made by the lowest set bit.
    function automatic logic [3:0] lowest_set(input logic [15:0] w);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // A strobe that stays high produces exactly one event.
    assign byte_ev  = rx_irq & ~irq_d_q;
    assign new_word = {hi_q, lo_q};

`ifdef KEY_EDGE_EN
    logic [15:0] press_q, press_d;
    logic [15:0] release_q, release_d;
`endif

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        keyout_d      = keyout_q;
        key_valid_d   = 1'b0;
        key_any_d     = key_any_q;
        key_code_d    = key_code_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = 1'b0;
`ifdef KEY_EDGE_EN
        press_d       = press_q;
        release_d     = release_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (byte_ev) begin
                    hi_d    = rx_data;
                    timer_d = '0;
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                // A byte on the expiry cycle still completes the frame.
                if (byte_ev) begin
                    lo_d    = rx_data;
                    state_d = S_COMMIT;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    hi_d          = 8'h00;
                    timer_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                keyout_d    = new_word;
                key_valid_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
                key_any_d   = |new_word;
                key_code_d  = lowest_set(new_word);
`ifdef KEY_EDGE_EN
                press_d     = new_word & ~keyout_q;
                release_d   = keyout_q & ~new_word;
`endif
                if (byte_ev) begin
                    hi_d    = rx_data;
                    timer_d = '0;
                    state_d = S_WAIT_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            irq_d_q       <= 1'b0;
            timer_q       <= '0;
            hi_q          <= 8'h00;
            lo_q          <= 8'h00;
            keyout_q      <= 16'h0000;
            key_valid_q   <= 1'b0;
            key_any_q     <= 1'b0;
            key_code_q    <= 4'd0;
            frame_cnt_q   <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_d_q       <= rx_irq;
            timer_q       <= timer_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            keyout_q      <= keyout_d;
            key_valid_q   <= key_valid_d;
            key_any_q     <= key_any_d;
            key_code_q    <= key_code_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef KEY_EDGE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_q   <= 16'h0000;
            release_q <= 16'h0000;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_mask   = press_q;
    assign release_mask = release_q;
`else
    assign press_mask   = 16'h0000;
    assign release_mask = 16'h0000;
`endif

    assign keyout      = keyout_q;
    assign key_valid   = key_valid_q;
    assign key_any     = key_any_q;
    assign key_code    = key_code_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_key_frame_rx.sv
module tb_key_frame_rx;

    logic        clk;
    logic        rst;
    logic        rx_irq;
    logic [7:0]  rx_data;
    logic [15:0] keyout;
    logic        key_valid;
    logic        key_any;
    logic [3:0]  key_code;
    logic [7:0]  frame_cnt;
    logic        timeout_err;
    logic [15:0] press_mask;
    logic [15:0] release_mask;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int kv_cnt = 0;
    int to_cnt = 0;
    int to_cyc = 0;

    key_frame_rx #(.TIMEOUT_CYCLES(100), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_irq       (rx_irq),
        .rx_data      (rx_data),
        .keyout       (keyout),
        .key_valid    (key_valid),
        .key_any      (key_any),
        .key_code     (key_code),
        .frame_cnt    (frame_cnt),
        .timeout_err  (timeout_err),
        .press_mask   (press_mask),
        .release_mask (release_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    // On return the event has just been sampled. The caller is at that edge + 1.
    task automatic send_byte(input logic [7:0] d);
        @(posedge clk); #1;
        rx_irq  = 1'b1;
        rx_data = d;
        @(posedge clk); #1;
        rx_irq  = 1'b0;
    endtask

    task automatic do_reset();
        rx_irq = 1'b0; rx_data = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_irq = 1'b0; rx_data = 8'h00;
        #2 rst = 1'b0;
        #20;
        total++;
        if ({keyout, key_valid, key_any, key_code, frame_cnt, timeout_err, press_mask, release_mask} !== 63'd0) begin
            bad++; $display("FAIL reset_outputs: got keyout=%h fc=%0d kv=%b to=%b, want all zero",
                            keyout, frame_cnt, key_valid, timeout_err);
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_basic_frame();
        int kv0;
        kv0 = kv_cnt;
        send_byte(8'h00);
        repeat (9) @(posedge clk);
        send_byte(8'h05);
        total++;
        if (keyout !== 16'h0000) begin
            bad++; $display("FAIL basic_early: keyout=%h before commit edge, want 0000", keyout);
        end
        @(posedge clk); #1;
        total++;
        if (keyout !== 16'h0005 || key_code !== 4'd0 || key_any !== 1'b1 || key_valid !== 1'b1) begin
            bad++; $display("FAIL basic_frame: keyout=%h code=%0d any=%b kv=%b, want 0005 0 1 1",
                            keyout, key_code, key_any, key_valid);
        end
        total++;
        if (frame_cnt !== 8'd1) begin
            bad++; $display("FAIL basic_cnt: frame_cnt=%0d want 1", frame_cnt);
        end
        @(posedge clk); #1;
        total++;
        if (key_valid !== 1'b0 || keyout !== 16'h0005) begin
            bad++; $display("FAIL basic_pulse: kv=%b keyout=%h, want 0 0005", key_valid, keyout);
        end
        repeat (3) @(posedge clk); #1;
        total++;
        if (kv_cnt - kv0 !== 1) begin
            bad++; $display("FAIL basic_kv_count: pulses=%0d want 1", kv_cnt - kv0);
        end
    endtask

    task automatic test_held_strobe();
        int kv0;
        kv0 = kv_cnt;
        @(posedge clk); #1;
        rx_irq = 1'b1; rx_data = 8'h80;
        repeat (20) @(posedge clk);
        #1 rx_irq = 1'b0;
        send_byte(8'h00);
        repeat (4) @(posedge clk); #1;
        total++;
        if (keyout !== 16'h8000 || key_code !== 4'd15 || key_any !== 1'b1) begin
            bad++; $display("FAIL held_strobe: keyout=%h code=%0d any=%b, want 8000 15 1",
                            keyout, key_code, key_any);
        end
        total++;
        if (kv_cnt - kv0 !== 1 || frame_cnt !== 8'd2) begin
            bad++; $display("FAIL held_frames: pulses=%0d fc=%0d, want 1 2", kv_cnt - kv0, frame_cnt);
        end
    endtask

    task automatic test_timeout();
        int hi_cyc, to0;
        to0 = to_cnt;
        send_byte(8'h12);
        hi_cyc = cyc;
        repeat (110) @(posedge clk); #1;
        total++;
        if (to_cnt - to0 !== 1 || to_cyc - hi_cyc !== 100) begin
            bad++; $display("FAIL timeout_pulse: pulses=%0d at=%0d, want 1 at 100",
                            to_cnt - to0, to_cyc - hi_cyc);
        end
        total++;
        if (keyout !== 16'h8000 || frame_cnt !== 8'd2) begin
            bad++; $display("FAIL timeout_hold: keyout=%h fc=%0d, want 8000 2", keyout, frame_cnt);
        end
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (2) @(posedge clk); #1;
        total++;
        if (keyout !== 16'h0001 || key_code !== 4'd0 || frame_cnt !== 8'd3) begin
            bad++; $display("FAIL resync: keyout=%h code=%0d fc=%0d, want 0001 0 3",
                            keyout, key_code, frame_cnt);
        end
    endtask

    task automatic test_expiry_edge();
        int to0;
        to0 = to_cnt;
        send_byte(8'h01);
        repeat (98) @(posedge clk);
        send_byte(8'h20);
        repeat (5) @(posedge clk); #1;
        total++;
        if (to_cnt !== to0 || keyout !== 16'h0120 || key_code !== 4'd5 || frame_cnt !== 8'd4) begin
            bad++; $display("FAIL expiry_edge: to=%0d keyout=%h code=%0d fc=%0d, want 0 0120 5 4",
                            to_cnt - to0, keyout, key_code, frame_cnt);
        end
    endtask

    task automatic test_wrap();
        int kv0;
        do_reset();
        kv0 = kv_cnt;
        for (int i = 0; i < 255; i++) begin
            send_byte(8'h00);
            send_byte(8'h00);
        end
        repeat (2) @(posedge clk); #1;
        total++;
        if (frame_cnt !== 8'd255) begin
            bad++; $display("FAIL wrap_255: fc=%0d want 255", frame_cnt);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(posedge clk); #1;
        total++;
        if (frame_cnt !== 8'd0 || kv_cnt - kv0 !== 256 || key_any !== 1'b0 || key_code !== 4'd0) begin
            bad++; $display("FAIL wrap_0: fc=%0d pulses=%0d any=%b code=%0d, want 0 256 0 0",
                            frame_cnt, kv_cnt - kv0, key_any, key_code);
        end
    endtask

    task automatic test_midframe_reset();
        send_byte(8'h00);
        send_byte(8'h09);
        send_byte(8'hAB);
        @(posedge clk); #1 rst = 1'b0;
        #3;
        total++;
        if (keyout !== 16'h0 || frame_cnt !== 8'd0 || key_any !== 1'b0 || key_code !== 4'd0) begin
            bad++; $display("FAIL midreset: keyout=%h fc=%0d any=%b, want 0 0 0", keyout, frame_cnt, key_any);
        end
        @(posedge clk); #1 rst = 1'b1;
        send_byte(8'h00);
        send_byte(8'h07);
        repeat (2) @(posedge clk); #1;
        total++;
        if (keyout !== 16'h0007 || frame_cnt !== 8'd1 || key_code !== 4'd0) begin
            bad++; $display("FAIL midreset_fresh: keyout=%h fc=%0d, want 0007 1", keyout, frame_cnt);
        end
    endtask

    task automatic test_edges();
        send_byte(8'h00);
        send_byte(8'h03);
        repeat (2) @(posedge clk);
        send_byte(8'h00);
        send_byte(8'h06);
        @(posedge clk); #1;
        total++;
        if (keyout !== 16'h0006 || key_code !== 4'd1 || key_valid !== 1'b1) begin
            bad++; $display("FAIL edge_frame: keyout=%h code=%0d kv=%b, want 0006 1 1", keyout, key_code, key_valid);
        end
`ifdef KEY_EDGE_EN
        total++;
        if (press_mask !== 16'h0004 || release_mask !== 16'h0001) begin
            bad++; $display("FAIL edge_masks: press=%h release=%h, want 0004 0001", press_mask, release_mask);
        end
`else
        total++;
        if (press_mask !== 16'h0000 || release_mask !== 16'h0000) begin
            bad++; $display("FAIL edge_masks_off: press=%h release=%h, want 0000 0000", press_mask, release_mask);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_held_strobe();
        test_timeout();
        test_expiry_edge();
        test_wrap();
        test_midframe_reset();
        test_edges();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
